// File: rtl/instr_sequencer.sv
// Instruction step sequencer: walks a per-opcode list of states for control_matrix,
// inserts RAM wait states, and provides run/halt/step control, sticky errors and a counter.
module instr_sequencer #(
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic [3:0]       opcode,
  input  logic             ram_ready,
  input  logic             clr_err,
  output logic [2:0]       state,
  output logic [3:0]       opcode_q,
  output logic             instr_done,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_EX1   = 3'd1;
  localparam logic [2:0] S_EX2   = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_MEMWR = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_CLEAR = 3'd6;
  localparam logic [2:0] S_HALT  = 3'd7;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b0001;
  localparam logic [3:0] OP_LDW = 4'b0010;
  localparam logic [3:0] OP_STW = 4'b0011;
  localparam logic [3:0] OP_RTR = 4'b0100;
  localparam logic [3:0] OP_BLT = 4'b0101;
  localparam logic [3:0] OP_ADD = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b0111;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       opcode_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             single_q, single_d;
  logic             from_reset_q, from_reset_d;
  logic             instr_done_q, instr_done_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ill_set_s, tmo_set_s;

  // Next-state, wait counter and instruction bookkeeping.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    wait_cnt_d   = wait_cnt_q;
    single_d     = single_q;
    from_reset_d = 1'b0;
    count_d      = count_q;
    ill_set_s    = 1'b0;
    tmo_set_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        opcode_d = opcode;
        if (opcode == OP_NOP)      state_d = S_CLEAR;
        else if (opcode == OP_HLT) state_d = S_HALT;
        else                       state_d = S_EX1;
      end
      S_EX1: begin
        case (opcode_q)
          OP_JMP:                 state_d = S_CLEAR;
          OP_LDW, OP_STW, OP_BLT: state_d = S_EX2;
          OP_RTR, OP_ADD, OP_SUB: state_d = S_WB;
          default: begin
            state_d   = S_CLEAR;
            ill_set_s = 1'b1;
          end
        endcase
      end
      S_EX2: begin
        if (opcode_q == OP_LDW)      state_d = ram_ready ? S_WB : S_WAIT;
        else if (opcode_q == OP_STW) state_d = S_MEMWR;
        else                         state_d = S_CLEAR;
      end
      S_WB:    state_d = S_CLEAR;
      S_MEMWR: state_d = ram_ready ? S_CLEAR : S_WAIT;
      S_WAIT: begin
        // ram_ready is checked first so a late ready still completes the access
        if (ram_ready) begin
          wait_cnt_d = 16'd0;
          state_d    = (opcode_q == OP_LDW) ? S_WB : S_CLEAR;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          wait_cnt_d = 16'd0;
          state_d    = S_CLEAR;
          tmo_set_s  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      S_CLEAR: begin
        if (!from_reset_q) count_d = count_q + CNT_W'(1);
        else               count_d = count_q;
        single_d = 1'b0;
        if (!single_q && run && !halt_req) state_d = S_FETCH;
        else                               state_d = S_HALT;
      end
      S_HALT: begin
        if (run && !halt_req) begin
          state_d  = S_FETCH;
          single_d = 1'b0;
        end else if (step) begin
          state_d  = S_FETCH;
          single_d = 1'b1;
        end else begin
          state_d  = S_HALT;
        end
      end
      default: state_d = S_CLEAR;
    endcase
    illegal_d    = ill_set_s | (illegal_q & ~clr_err);
    timeout_d    = tmo_set_s | (timeout_q & ~clr_err);
    instr_done_d = (state_d == S_CLEAR);
    halted_d     = (state_d == S_HALT);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_CLEAR;
      opcode_q     <= 4'b0000;
      wait_cnt_q   <= 16'd0;
      single_q     <= 1'b0;
      from_reset_q <= 1'b1;
      instr_done_q <= 1'b1;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      wait_cnt_q   <= wait_cnt_d;
      single_q     <= single_d;
      from_reset_q <= from_reset_d;
      instr_done_q <= instr_done_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
    end
  end

  assign state       = state_q;
  assign instr_done  = instr_done_q;
  assign halted      = halted_q;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;
  assign instr_count = count_q;

endmodule
